fetch_queue: RTL

Instruction fetch front end with a prefetch buffer. It sits between the synchronous instruction ROM and the IF/ID pipeline register.
- Owns the 13-bit PC and issues one ROM read per cycle while buffer credit exists.
- Queues returned instructions together with their PC.
- Presents instructions to decode through a valid/ready handshake.
- On a taken branch, flushes all wrong-path state and redirects the PC.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_queue_if.sv | 34 +++
 rtl/fetch_fifo.sv | 83 ++++++++
 rtl/fetch_queue.sv | 104 ++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch front end.
//   FETCH_ARQ    : default instruction width in bits
//   FETCH_ADDR_W : default PC / instruction address width
//   NOP_INSTR    : value shown on instr_out when nothing is queued
//   fetch_entry_t: one queue slot, the instruction tagged with its PC
package fetch_pkg;

    localparam int FETCH_ARQ    = 16;
    localparam int FETCH_ADDR_W = 13;

    localparam logic [FETCH_ARQ-1:0] NOP_INSTR = 16'h0000;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_ARQ-1:0]    instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: the bus signals of the fetch front end.
//   ROM side    : imem_en / imem_addr out, imem_data in (one cycle after imem_en)
//   decode side : out_valid / instr_out / pc_out out, out_ready in
// Handshake: an entry transfers on a rising edge where out_valid and
// out_ready are both 1. out_valid never depends on out_ready, and while
// out_valid=1 and out_ready=0 the head (out_valid, instr_out, pc_out)
// stays unchanged. out_ready is ignored while out_valid=0.
// master = the fetch queue, slave = the ROM / decode environment.
interface fetch_queue_if
    import fetch_pkg::*;
#(
    parameter int ARQ              = FETCH_ARQ,
    parameter int MEMORY_ADDR_SIZE = FETCH_ADDR_W
) ();

    logic                        imem_en;
    logic [MEMORY_ADDR_SIZE-1:0] imem_addr;
    logic [ARQ-1:0]              imem_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [ARQ-1:0]              instr_out;
    logic [MEMORY_ADDR_SIZE-1:0] pc_out;

    modport master (
        output imem_en, imem_addr, out_valid, instr_out, pc_out,
        input  imem_data, out_ready
    );

    modport slave (
        input  imem_en, imem_addr, out_valid, instr_out, pc_out,
        output imem_data, out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry FIFO of fetch_entry_t.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : synchronous clear; wins over push and pop on the same edge
//   push       : write push_data at the write pointer (caller never pushes when full)
//   pop        : advance the read pointer (caller never pops when empty)
//   head       : entry at the read pointer
//   count      : number of occupied entries (0..DEPTH)
//   empty/full : occupancy flags
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t    mem_q [DEPTH];
    fetch_entry_t    mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                // DEPTH is a power of two, so the pointer wraps on overflow.
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset: an entry is only visible once count covers it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end with a prefetch buffer.
//   clk          : clock, all state updates on the rising edge
//   rst          : synchronous active-high reset, overrides every other input
//   fetch_en     : permits new ROM reads (a read already in flight still lands)
//   branch_taken : redirect request; flushes queue and in-flight read
//   jaddr        : branch target
//   bus          : ROM read port and decode valid/ready port (fetch_queue_if)
// ARQ / MEMORY_ADDR_SIZE must match the widths of fetch_entry_t.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                          ARQ              = FETCH_ARQ,
    parameter int                          MEMORY_ADDR_SIZE = FETCH_ADDR_W,
    parameter int                          DEPTH            = 4,
    parameter logic [MEMORY_ADDR_SIZE-1:0] RESET_PC         = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fetch_en,
    input  logic                        branch_taken,
    input  logic [MEMORY_ADDR_SIZE-1:0] jaddr,
    fetch_queue_if.master               bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [MEMORY_ADDR_SIZE-1:0] pc_q, pc_d;
    logic [MEMORY_ADDR_SIZE-1:0] shadow_pc_q, shadow_pc_d;
    logic                        inflight_q, inflight_d;

    logic [CW-1:0]  fifo_count;
    logic           fifo_empty;
    logic           fifo_full;
    fetch_entry_t   fifo_head;
    fetch_entry_t   push_entry;
    logic [CW:0]    credit_used;
    logic           issue;
    logic           push;
    logic           pop;

    always_comb begin
        // A read is only issued if the slot it will land in is already
        // reserved: queued entries plus the in-flight read must leave room.
        // A pop in this same cycle does not count, so overflow is impossible.
        credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
        issue       = !rst && fetch_en && !branch_taken
                      && (credit_used < (CW+1)'(DEPTH));

        // Returning data belongs to the wrong path during a redirect.
        push = inflight_q && !branch_taken && !fifo_full;
        pop  = !fifo_empty && bus.out_ready && !branch_taken;

        push_entry.pc    = shadow_pc_q;
        push_entry.instr = bus.imem_data;

        pc_d        = pc_q;
        shadow_pc_d = shadow_pc_q;
        inflight_d  = inflight_q;
        if (branch_taken) begin
            pc_d       = jaddr;
            inflight_d = 1'b0;
        end else if (issue) begin
            pc_d        = pc_q + MEMORY_ADDR_SIZE'(1);
            shadow_pc_d = pc_q;
            inflight_d  = 1'b1;
        end else if (inflight_q) begin
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            shadow_pc_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            shadow_pc_q <= shadow_pc_d;
            inflight_q  <= inflight_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (branch_taken),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign bus.imem_en   = issue;
    assign bus.imem_addr = pc_q;
    assign bus.out_valid = !fifo_empty;
    assign bus.instr_out = fifo_empty ? NOP_INSTR : fifo_head.instr;
    assign bus.pc_out    = fifo_empty ? '0 : fifo_head.pc;

endmodule
